// File: rtl/gcapply.sv
// Per-bin gain application between FFT and IFFT: 3-stage multiply / round / saturate
// pipeline with a per-frame unity-gain mode latch and a bin-sequence checker.
module gcapply #(
  parameter int LOGFFTSIZE = 12,
  parameter int AUDIOWIDTH = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  bypass,
  input  logic                  recompute_done,
  input  logic                  fft_valid,
  input  logic [LOGFFTSIZE-1:0] fft_index,
  input  logic [AUDIOWIDTH-1:0] fft_re,
  input  logic [AUDIOWIDTH-1:0] fft_im,
  output logic [LOGFFTSIZE-1:0] gcurve_addr,
  input  logic [AUDIOWIDTH-1:0] gcurve_dout,
  output logic                  ifft_valid,
  output logic [LOGFFTSIZE-1:0] ifft_index,
  output logic [AUDIOWIDTH-1:0] ifft_re,
  output logic [AUDIOWIDTH-1:0] ifft_im,
  output logic                  frame_done,
  output logic                  seq_err,
  output logic                  unity_active
);

  localparam int L  = LOGFFTSIZE;
  localparam int W  = AUDIOWIDTH;
  localparam int PW = 2 * W + 1;

  localparam logic [L-1:0]          ZERO_IDX   = {L{1'b0}};
  localparam logic [L-1:0]          LAST_IDX   = {L{1'b1}};
  localparam logic [L-1:0]          ONE_IDX    = {{(L-1){1'b0}}, 1'b1};
  localparam logic [W-1:0]          UNITY_GAIN = {1'b1, {(W-1){1'b0}}};
  localparam logic signed [PW-1:0]  RND_HALF   = {{(W+2){1'b0}}, 1'b1, {(W-2){1'b0}}};
  localparam logic signed [PW-1:0]  SAT_MAX    = {{(W+2){1'b0}}, {(W-1){1'b1}}};
  localparam logic signed [PW-1:0]  SAT_MIN    = {{(W+2){1'b1}}, {(W-1){1'b0}}};

  // Round half up at the Q(W-1) point, then clamp into the signed output range.
  function automatic logic [W-1:0] round_sat(input logic signed [PW-1:0] p);
    logic signed [PW-1:0] r;
    r = (p + RND_HALF) >>> (W - 1);
    if (r > SAT_MAX) begin
      round_sat = SAT_MAX[W-1:0];
    end else if (r < SAT_MIN) begin
      round_sat = SAT_MIN[W-1:0];
    end else begin
      round_sat = r[W-1:0];
    end
  endfunction

  logic                 use_unity_r;
  logic [L-1:0]         expected_index_r;
  logic                 seq_err_r;

  logic                 s1_valid_r;
  logic [L-1:0]         s1_index_r;
  logic [W-1:0]         s1_re_r;
  logic [W-1:0]         s1_im_r;
  logic                 s1_unity_r;

  logic                 s2_valid_r;
  logic [L-1:0]         s2_index_r;
  logic signed [PW-1:0] s2_p_re_r;
  logic signed [PW-1:0] s2_p_im_r;
  logic                 s2_unity_r;

  logic                 out_valid_r;
  logic [L-1:0]         out_index_r;
  logic [W-1:0]         out_re_r;
  logic [W-1:0]         out_im_r;
  logic                 frame_done_r;
  logic                 unity_active_r;

  logic                 frame_start_s;
  logic                 bin_unity_s;
  logic [W-1:0]         gain_s;
  logic signed [PW-1:0] re_x_s;
  logic signed [PW-1:0] im_x_s;
  logic signed [PW-1:0] gain_x_s;

  assign gcurve_addr = fft_index;

  // Index 0 opens a frame and decides its gain mode; other bins inherit it.
  always_comb begin
    frame_start_s = fft_valid && (fft_index == ZERO_IDX);
    if (frame_start_s) begin
      bin_unity_s = bypass | ~recompute_done;
    end else begin
      bin_unity_s = use_unity_r;
    end
  end

  // S2 operands: RAM word arrives while the bin sits in S1.
  always_comb begin
    if (s1_unity_r) begin
      gain_s = UNITY_GAIN;
    end else begin
      gain_s = gcurve_dout;
    end
    re_x_s   = {{(W+1){s1_re_r[W-1]}}, s1_re_r};
    im_x_s   = {{(W+1){s1_im_r[W-1]}}, s1_im_r};
    gain_x_s = {{(W+1){1'b0}}, gain_s};
  end

  // Frame mode latch and sequence checker.
  always_ff @(posedge clk) begin
    if (rst) begin
      use_unity_r      <= 1'b1;
      expected_index_r <= ZERO_IDX;
      seq_err_r        <= 1'b0;
    end else if (fft_valid) begin
      use_unity_r      <= bin_unity_s;
      expected_index_r <= fft_index + ONE_IDX;
      if (!frame_start_s && (fft_index != expected_index_r)) begin
        seq_err_r <= 1'b1;
      end
    end
  end

  // Valid bits move every cycle; rst flushes everything in flight.
  always_ff @(posedge clk) begin
    if (rst) begin
      s1_valid_r   <= 1'b0;
      s2_valid_r   <= 1'b0;
      out_valid_r  <= 1'b0;
      frame_done_r <= 1'b0;
    end else begin
      s1_valid_r   <= fft_valid;
      s2_valid_r   <= s1_valid_r;
      out_valid_r  <= s2_valid_r;
      frame_done_r <= s2_valid_r && (s2_index_r == LAST_IDX);
    end
  end

  // Datapath stages load only behind a valid bin and otherwise hold.
  always_ff @(posedge clk) begin
    if (rst) begin
      s1_index_r     <= ZERO_IDX;
      s1_re_r        <= {W{1'b0}};
      s1_im_r        <= {W{1'b0}};
      s1_unity_r     <= 1'b1;
      s2_index_r     <= ZERO_IDX;
      s2_p_re_r      <= {PW{1'b0}};
      s2_p_im_r      <= {PW{1'b0}};
      s2_unity_r     <= 1'b1;
      out_index_r    <= ZERO_IDX;
      out_re_r       <= {W{1'b0}};
      out_im_r       <= {W{1'b0}};
      unity_active_r <= 1'b1;
    end else begin
      if (fft_valid) begin
        s1_index_r <= fft_index;
        s1_re_r    <= fft_re;
        s1_im_r    <= fft_im;
        s1_unity_r <= bin_unity_s;
      end
      if (s1_valid_r) begin
        s2_index_r <= s1_index_r;
        s2_p_re_r  <= re_x_s * gain_x_s;
        s2_p_im_r  <= im_x_s * gain_x_s;
        s2_unity_r <= s1_unity_r;
      end
      if (s2_valid_r) begin
        out_index_r    <= s2_index_r;
        out_re_r       <= round_sat(s2_p_re_r);
        out_im_r       <= round_sat(s2_p_im_r);
        unity_active_r <= s2_unity_r;
      end
    end
  end

  assign ifft_valid   = out_valid_r;
  assign ifft_index   = out_index_r;
  assign ifft_re      = out_re_r;
  assign ifft_im      = out_im_r;
  assign frame_done   = frame_done_r;
  assign seq_err      = seq_err_r;
  assign unity_active = unity_active_r;

endmodule

// File: doc/gcapply.md
# gcapply

Applies the per-bin gain curve to the streaming FFT output before it enters the IFFT. Each valid FFT bin looks up its gain in the gain-curve RAM (the one `gcrecomp` fills) through a 1-cycle-latency read port, multiplies real and imaginary parts by the gain, then rounds and saturates the result. It also tracks frame boundaries and bin-sequence errors. The block is fully pipelined: one bin per clock, no backpressure.

## Interface
- LOGFFTSIZE, 12, log2 of bins per frame; gain RAM depth is 2^LOGFFTSIZE.
- AUDIOWIDTH, 16, width of the sample and gain words.
- clk  in  1  clock.
- rst  in  1  reset: synchronous, active-high, clock clk.
- bypass  in  1  force unity gain; sampled at frame start only.
- recompute_done  in  1  high when the gain curve is stable.
- fft_valid  in  1  input bin qualifier.
- fft_index  in  LOGFFTSIZE  bin number.
- fft_re, fft_im  in  AUDIOWIDTH each  signed bin value.
- gcurve_addr  out  LOGFFTSIZE  RAM read address; combinational, equals fft_index.
- gcurve_dout  in  AUDIOWIDTH  unsigned gain; unity is 2^(AUDIOWIDTH-1); valid 1 cycle after the address.
- ifft_valid  out  1  output qualifier.
- ifft_index  out  LOGFFTSIZE  bin number of the output.
- ifft_re, ifft_im  out  AUDIOWIDTH each  scaled signed result.
- frame_done  out  1  1-cycle pulse when the last bin (index 2^LOGFFTSIZE-1) leaves the output.
- seq_err  out  1  sticky; set on a bin-index discontinuity, cleared only by rst.
- unity_active  out  1  high while the current frame uses unity gain.

## Operation
Pipeline (S1–S3):
- S1 registers valid, index, re, im; the RAM read is in flight.
- S2 forms both products:
  - p = re × {1'b0, gain}, signed, 2·AUDIOWIDTH+1 bits.
  - When the frame is in unity mode, gain is replaced by 2^(AUDIOWIDTH-1).
- S3 computes the output:
  - r = (p + 2^(AUDIOWIDTH-2)) >>> (AUDIOWIDTH-1), arithmetic shift (round half up).
  - Saturate r to [-2^(AUDIOWIDTH-1), 2^(AUDIOWIDTH-1)-1].
  - Drive ifft_*.

Frame mode latch:
- When fft_valid is high and fft_index==0, latch use_unity = bypass | ~recompute_done.
- The latched mode holds for every bin of that frame, tracked with its bin through the pipeline.
- A recompute that starts mid-frame therefore does not change the mode of the frame in flight. The RAM contents are still read live.

Sequence checker:
- expected_index is reset to 0.
- On each valid bin, if fft_index ≠ expected_index, set seq_err.
- In all cases, expected_index becomes fft_index+1, wrapping at 2^LOGFFTSIZE.
- Index 0 is always accepted as a resync point: it sets no error and starts a new frame.

## Timing
- Latency: 3 cycles from fft_valid to ifft_valid. Throughput: 1 bin per cycle.
- Gaps in fft_valid propagate unchanged. Datapath registers hold their values when invalid; only the valid bits move.
- frame_done asserts in the same cycle as ifft_valid for the bin with index 2^LOGFFTSIZE-1.
- Reset values: ifft_valid=0, ifft_index=0, ifft_re=0, ifft_im=0, frame_done=0, seq_err=0, unity_active=1. Internally, use_unity=1 and expected_index=0.
- rst mid-frame: all pipeline valids clear the following cycle; no partial output is emitted afterwards.
- unity_active reflects the mode of the bin at S3. Before the first index-0 bin it stays 1.
- Wrap-around: index 2^LOGFFTSIZE-1 followed by 0 is legal, with no seq_err.
- If fft_index==0 and rst are high in the same cycle, rst wins.

## Test plan
All values assume AUDIOWIDTH=16 and LOGFFTSIZE=12, streaming a full frame.
- Gain RAM model holds 0x8000 for all bins, re=1000, im=-1000 → ifft_re=1000, ifft_im=-1000, exactly 3 cycles after input; frame_done on the last bin.
- gain=0xFFFF, re=1000 → 2000. re=30000 → 32767 (saturated). re=-32768 → -32768.
- gain=0x4000: re=-3 → -1; re=3 → 2; re=1 → 1 (round half up).
- recompute_done=0 at index 0, then raised at bin 100 with gain RAM at 0x4000 → whole frame passes unity (re=800 out as 800) and unity_active stays 1. The next frame, with recompute_done=1, outputs 400.
- Indices 0,1,2,5,6 → seq_err rises on the bin-5 cycle and stays high. A later restart at 0 does not clear it; only rst clears it.
- Assert rst for 1 cycle at bin 50 with valid continuous → no ifft_valid from bins 48–50. All outputs at reset values. Input resuming at index 0 gives correct output after 3 cycles.
